// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud-divider helper.
// Used by both the receiver and transmitter so their state names line up.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int TICK_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } uart_state_e;

    // Clock cycles per serial bit; integer division, remainder dropped.
    function automatic int ticks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signals: serial pin in, framed byte and status strobes out.
// The receiver takes the master modport; the consumer side takes slave.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input pin; resets to RESET_VAL
// so an idle-high line does not look like activity coming out of reset.
module uart_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: start-bit qualification at mid-bit, LSB-first data
// sampling at bit centres, stop-bit check and one-cycle valid/error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);

    localparam int TICKS_PER_BIT = ticks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT      = TICKS_PER_BIT / 2;

    localparam logic [TICK_W-1:0] TICK_BIT_LAST  = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(HALF_BIT - 1);
    localparam logic [2:0]        BIT_LAST       = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    uart_state_e          state_q,     state_d;
    logic [TICK_W-1:0]    tick_cnt_q,  tick_cnt_d;
    logic [2:0]           bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 rx_ferr_q,   rx_ferr_d;
    logic                 rx_busy_q,   rx_busy_d;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            // A start bit that is high again at its centre was a glitch.
            ST_START: begin
                if (tick_cnt_q == TICK_HALF_LAST) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (tick_cnt_q == TICK_BIT_LAST) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (tick_cnt_q == TICK_BIT_LAST) begin
                    tick_cnt_d = '0;
                    state_d    = ST_CLEANUP;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_ferr_d  = 1'b1;
                    end
                end
            end

            // Hold off while the line is low so a break is not read as a start.
            ST_CLEANUP: begin
                tick_cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                tick_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_frame_err = rx_ferr_q;
    assign bus.rx_busy      = rx_busy_q;

endmodule
